// File: rtl/led_pkg.sv
// Shared types and helpers for the thermometer LED serializer.
// Provides the FSM state encoding, default sizes and the thermometer-code check.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    localparam int DEFAULT_DATA_W  = 8;
    localparam int DEFAULT_CLK_DIV = 2;

    // True for 2^k-1 with 1 <= k <= w: non-zero, all ones contiguous from bit 0, nothing above bit w-1.
    function automatic logic is_thermo(input logic [63:0] v, input int unsigned w);
        return (v != 64'd0) && ((v & (v + 64'd1)) == 64'd0) && ((v >> w) == 64'd0);
    endfunction

endpackage

// File: rtl/thermo_led_serializer_if.sv
// Pattern handshake between the thermometer pattern source and the LED serializer.
// master drives the pattern, slave (the serializer) answers with data_ready.
interface thermo_led_serializer_if
    import led_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/ser_phase_timer.sv
// Restartable phase counter for the serializer: raises tc on the last clk of every
// CLK_DIV-cycle phase; restart reloads the count to zero so each state gets a full phase.
module ser_phase_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic clear,
    input  logic restart,
    output logic tc
);
    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    assign tc = (cnt_r == TERM);

    // Phase count: reload on restart or at terminal, never counts past TERM.
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (restart || tc) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/thermo_led_serializer.sv
// Shifts one accepted bar pattern out on ser_clk/ser_data, then pulses ser_latch.
// Optional THERMO_CHECK_EN: reject non-thermometer patterns at accept and set sticky err.
module thermo_led_serializer
    import led_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int CLK_DIV   = DEFAULT_CLK_DIV,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    clear,
    thermo_led_serializer_if.slave  hs,
    output logic                    ser_clk,
    output logic                    ser_data,
    output logic                    ser_latch,
    output logic                    busy,
    output logic                    err
);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_t              state_r;
    state_t              state_next_s;
    logic [DATA_W-1:0]   shreg_r;
    logic [DATA_W-1:0]   shreg_next_s;
    logic [BIT_W-1:0]    bit_cnt_r;
    logic                ready_r;
    logic                tc_s;
    logic                restart_s;
    logic                accept_s;
    logic                pattern_ok_s;
    logic                start_s;
    logic                reject_s;
    logic                advance_s;

    function automatic logic first_bit(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? v[DATA_W-1] : v[0];
    endfunction

    assign hs.data_ready = ready_r;
    assign accept_s      = hs.data_valid & ready_r;

`ifdef THERMO_CHECK_EN
    assign pattern_ok_s = is_thermo(64'(hs.data_in), DATA_W);
`else
    assign pattern_ok_s = 1'b1;
`endif

    assign start_s      = accept_s & pattern_ok_s;
    assign reject_s     = accept_s & ~pattern_ok_s;
    assign shreg_next_s = MSB_FIRST ? {shreg_r[DATA_W-2:0], 1'b0} : {1'b0, shreg_r[DATA_W-1:1]};
    assign advance_s    = (state_r == SHIFT_HI) && (state_next_s == SHIFT_LO);
    assign restart_s    = (state_next_s != state_r);

    ser_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk     (clk),
        .clear   (clear),
        .restart (restart_s),
        .tc      (tc_s)
    );

    // Next-state decode; every state change also restarts the phase timer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) state_next_s = SHIFT_LO;
                else         state_next_s = IDLE;
            end
            SHIFT_LO: begin
                if (tc_s) state_next_s = SHIFT_HI;
                else      state_next_s = SHIFT_LO;
            end
            SHIFT_HI: begin
                if (tc_s) begin
                    if (bit_cnt_r == LAST_BIT) state_next_s = LATCH;
                    else                       state_next_s = SHIFT_LO;
                end else begin
                    state_next_s = SHIFT_HI;
                end
            end
            LATCH: begin
                if (tc_s) state_next_s = IDLE;
                else      state_next_s = LATCH;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, shift path and registered serial outputs; clear overrides any handshake.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_r   <= IDLE;
            shreg_r   <= {DATA_W{1'b0}};
            bit_cnt_r <= {BIT_W{1'b0}};
            ready_r   <= 1'b1;
            busy      <= 1'b0;
            ser_clk   <= 1'b0;
            ser_data  <= 1'b0;
            ser_latch <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            ser_clk   <= (state_next_s == SHIFT_HI);
            ser_latch <= (state_next_s == LATCH);
            // A rejected pattern still costs one not-ready cycle so the source sees the handshake.
            ready_r   <= (state_next_s == IDLE) && !reject_s;
            busy      <= !((state_next_s == IDLE) && !reject_s);
            if (start_s) begin
                shreg_r   <= hs.data_in;
                ser_data  <= first_bit(hs.data_in);
                bit_cnt_r <= {BIT_W{1'b0}};
            end else if (advance_s) begin
                shreg_r   <= shreg_next_s;
                ser_data  <= first_bit(shreg_next_s);
                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            end else if ((state_next_s == LATCH) || (state_next_s == IDLE)) begin
                shreg_r   <= shreg_r;
                ser_data  <= 1'b0;
                bit_cnt_r <= {BIT_W{1'b0}};
            end else begin
                shreg_r   <= shreg_r;
                ser_data  <= ser_data;
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    // Sticky pattern error flag.
    always_ff @(posedge clk) begin
        if (clear) begin
            err <= 1'b0;
        end else begin
`ifdef THERMO_CHECK_EN
            err <= err | reject_s;
`else
            err <= 1'b0;
`endif
        end
    end

endmodule
